// File: rtl/pow_engine.sv
// pow_engine: sequential square-and-multiply exponentiation p = c^g, one exponent bit per clock (optional POW_SAT_EN saturates p on overflow)
module pow_engine #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] c,
    input  logic [W-1:0] g,
    output logic [W-1:0] p,
    output logic         done,
    output logic         busy,
    output logic         ovf
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_n;
    logic [W-1:0] acc, b, e, acc_n, b_n, e_n, p_n, res;
    logic b_ovf, a_ovf, b_ovf_n, a_ovf_n, done_n, busy_n, ovf_n;
    logic [2*W-1:0] prod_a, prod_b;

    assign prod_a = acc * b;
    assign prod_b = b * b;

`ifdef POW_SAT_EN
    assign res = a_ovf ? '1 : acc;
`else
    assign res = acc;
`endif

    // State and datapath registers; reset wins over every update
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            acc   <= '0;
            b     <= '0;
            e     <= '0;
            b_ovf <= 1'b0;
            a_ovf <= 1'b0;
            p     <= '0;
            done  <= 1'b0;
            busy  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            b     <= b_n;
            e     <= e_n;
            b_ovf <= b_ovf_n;
            a_ovf <= a_ovf_n;
            p     <= p_n;
            done  <= done_n;
            busy  <= busy_n;
            ovf   <= ovf_n;
        end
    end

    // Next state: accept in IDLE, consume one exponent bit per RUN cycle, publish when e drains
    always_comb begin
        state_n = state;
        acc_n   = acc;
        b_n     = b;
        e_n     = e;
        b_ovf_n = b_ovf;
        a_ovf_n = a_ovf;
        p_n     = p;
        done_n  = 1'b0;
        busy_n  = busy;
        ovf_n   = ovf;
        case (state)
            IDLE: if (start) begin
                acc_n   = W'(1);
                b_n     = c;
                e_n     = g;
                b_ovf_n = 1'b0;
                a_ovf_n = 1'b0;
                busy_n  = 1'b1;
                state_n = RUN;
            end
            RUN: if (e != '0) begin
                if (e[0]) begin
                    acc_n   = prod_a[W-1:0];
                    a_ovf_n = a_ovf | (|prod_a[2*W-1:W]) | (b_ovf & (|acc));
                end
                b_n     = prod_b[W-1:0];
                b_ovf_n = b_ovf | (|prod_b[2*W-1:W]);
                e_n     = e >> 1;
            end else begin
                p_n     = res;
                ovf_n   = a_ovf;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: doc/pow_engine.md
# pow_engine

Sequential integer exponentiation unit computing p = c^g by right-to-left square-and-multiply, one exponent bit per clock. It is the inverse companion of the team's iterative integer-logarithm block: that block finds the exponent for a given base and bound, while this one regenerates the power from a base and exponent. It is used to produce and check bounds for that block. It uses a start/done handshake and has overflow reporting.

## Interface
- W, 16: width of base, exponent and result.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- c  input  W  base; captured on the accepted start edge.
- g  input  W  exponent; captured on the accepted start edge.
- p  output  W  result; holds its value until the next completion.
- done  output  1  one-cycle completion pulse.
- busy  output  1  high from the accepted start until the completion edge.
- ovf  output  1  true result exceeded 2^W-1; valid with done and held alongside p.

## Operation
- States: IDLE, RUN.
- Internal registers: acc (W), b (W), e (W), b_ovf (1), a_ovf (1).
- IDLE with start=1:
  - acc←1, b←c, e←g, b_ovf←0, a_ovf←0; go to RUN.
  - busy←1.
- IDLE with start=0: hold.
- RUN with e≠0 (one step per edge):
  - If e[0]=1: acc←low W bits of acc*b (2W-bit product). Set a_ovf if the high W bits are nonzero, or if b_ovf=1 and acc≠0.
  - b←low W bits of b*b. Set b_ovf (sticky) if the high half is nonzero.
  - e←e>>1.
- RUN with e=0:
  - p←acc, ovf←a_ovf, done←1, busy←0; go to IDLE.
- Squaring overflow is reported only if the overflowed b is actually multiplied in. Example: 256^1 has no overflow; 256^2 overflows.
- Special values: c=0, g=0 gives p=1. c=0, g>0 gives p=0 with ovf=0. c=1 gives p=1 for any g.
- start while busy is ignored and has no effect on the running operation.
- done deasserts on the edge after it was raised.

## Timing
- Reset values: p=0, done=0, busy=0, ovf=0; state=IDLE; all internal registers 0.
- Reset mid-operation aborts with no done pulse.
- L = bit length of g (0 for g=0, 16 for g≥0x8000).
- Latency: done is high in the cycle following edge L+1, counted from the accepted start edge (edge 0).
- Worst case at W=16: 17 edges.
- Back-to-back: start high in the done cycle is accepted, because the FSM is already IDLE. This gives one result every L+2 cycles.
- rst has priority over start and over every RUN update on the same edge.

## Configuration
- POW_SAT_EN defined: on overflow, p←{W{1'b1}} (saturate); ovf=1.
- POW_SAT_EN undefined: on overflow, p = true result mod 2^W (wrapped low bits); ovf=1.
- Non-overflow results are identical in both builds.

## Test plan
- c=3, g=5 (L=3), start pulsed one cycle:
  - done rises 4 edges after the start edge; p=243, ovf=0.
  - busy is high for the 4 edges between.
- g=0 with c=0 and with c=7:
  - done after 1 edge; p=1, ovf=0 in both cases.
- c=2, g=15: p=32768, ovf=0, latency 5 edges.
- c=2, g=16: ovf=1; p=0 without POW_SAT_EN, p=0xFFFF with it.
- Squaring-overflow path:
  - c=256, g=1: p=256, ovf=0.
  - c=256, g=2: ovf=1.
- Control:
  - rst asserted 2 edges into c=3, g=255: no done; all outputs return to 0.
  - start held high while busy does not disturb the result.
  - A new start in the done cycle (c=5, g=3) yields p=125.
